// File: rtl/tx_share_arbiter.sv
// rtl/tx_share_arbiter.sv - round-robin arbiter sharing one tx port among NCLI clients
// Latches the winner's word, holds it on sdata until snt, then pulses done and rotates priority.
module tx_share_arbiter #(
  parameter int NCLI     = 4,
  parameter int IDXW     = 2,
  parameter int DATA_MSB = 7
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NCLI-1:0]                cli_req,
  input  logic [NCLI*(DATA_MSB+1)-1:0]   cli_data,
  input  logic [NCLI-1:0]                cli_mask,
  output logic [NCLI-1:0]                cli_gnt,
  output logic [NCLI-1:0]                cli_done,
  output logic                           vi,
  output logic [DATA_MSB:0]              sdata,
  input  logic                           snt,
  output logic                           busy,
  output logic [IDXW-1:0]                cur_idx,
  output logic [15:0]                    stall_cnt
);

  localparam int W = DATA_MSB + 1;

  typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

  state_t            state_q;
  logic [IDXW-1:0]   ptr_q;
  logic [IDXW-1:0]   ptr_d;
  logic [IDXW-1:0]   cur_idx_q;
  logic [NCLI-1:0]   gnt_q;
  logic [NCLI-1:0]   done_q;
  logic              vi_q;
  logic              busy_q;
  logic [W-1:0]      sdata_q;
  logic [15:0]       stall_q;

  logic [NCLI-1:0]   elig;
  logic              win_found;
  logic [IDXW-1:0]   win_idx;
  logic [IDXW:0]     scan_sum;
  logic [W-1:0]      words [NCLI];

  // Scan eligible clients from ptr upward, wrapping at NCLI so unused indices are never visited.
  always_comb begin
    elig      = cli_req & ~cli_mask;
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    for (int k = 0; k < NCLI; k++) begin
      scan_sum = {1'b0, ptr_q} + (IDXW+1)'(k);
      if (scan_sum >= (IDXW+1)'(NCLI)) begin
        scan_sum = scan_sum - (IDXW+1)'(NCLI);
      end
      if (!win_found && elig[scan_sum[IDXW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_sum[IDXW-1:0];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCLI; i++) begin
      words[i] = cli_data[i*W +: W];
    end
  end

  assign ptr_d = (cur_idx_q == IDXW'(NCLI-1)) ? '0 : cur_idx_q + IDXW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cur_idx_q <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      vi_q      <= 1'b0;
      busy_q    <= 1'b0;
      sdata_q   <= '0;
      stall_q   <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (win_found) begin
            sdata_q          <= words[win_idx];
            cur_idx_q        <= win_idx;
            gnt_q[win_idx]   <= 1'b1;
            vi_q             <= 1'b1;
            busy_q           <= 1'b1;
            state_q          <= SEND;
          end
        end
        SEND: begin
          if (stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
          end
          // A stale high snt on entry counts as completion; RELEASE absorbs the level.
          if (snt) begin
            vi_q              <= 1'b0;
            done_q[cur_idx_q] <= 1'b1;
            ptr_q             <= ptr_d;
            state_q           <= RELEASE;
          end
        end
        RELEASE: begin
          if (!snt) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          vi_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cli_gnt   = gnt_q;
  assign cli_done  = done_q;
  assign vi        = vi_q;
  assign sdata     = sdata_q;
  assign busy      = busy_q;
  assign cur_idx   = cur_idx_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_tx_share_arbiter.sv
// tb/tb_tx_share_arbiter.sv - directed self-checking bench for tx_share_arbiter
module tb_tx_share_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  cli_req;
  logic [31:0] cli_data;
  logic [3:0]  cli_mask;
  logic [3:0]  cli_gnt;
  logic [3:0]  cli_done;
  logic        vi;
  logic [7:0]  sdata;
  logic        snt;
  logic        busy;
  logic [1:0]  cur_idx;
  logic [15:0] stall_cnt;

  int vecs = 0;
  int errs = 0;

  tx_share_arbiter #(.NCLI(4), .IDXW(2), .DATA_MSB(7)) dut (
    .clk       (clk),
    .reset     (reset),
    .cli_req   (cli_req),
    .cli_data  (cli_data),
    .cli_mask  (cli_mask),
    .cli_gnt   (cli_gnt),
    .cli_done  (cli_done),
    .vi        (vi),
    .sdata     (sdata),
    .snt       (snt),
    .busy      (busy),
    .cur_idx   (cur_idx),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic serve(input logic [1:0] idx, input logic [7:0] d, input int hold);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    cyc();
    chk("gnt", {28'd0, cli_gnt}, {28'd0, oh});
    chk("vi_up", {31'd0, vi}, 32'd1);
    chk("sdata", {24'd0, sdata}, {24'd0, d});
    chk("cur_idx", {30'd0, cur_idx}, {30'd0, idx});
    for (int i = 1; i < hold; i++) begin
      cyc();
      chk("gnt_pulse", {28'd0, cli_gnt}, 32'd0);
      chk("vi_hold", {31'd0, vi}, 32'd1);
      chk("sdata_hold", {24'd0, sdata}, {24'd0, d});
    end
    snt = 1'b1;
    cyc();
    chk("done", {28'd0, cli_done}, {28'd0, oh});
    chk("vi_drop", {31'd0, vi}, 32'd0);
    chk("busy_rel", {31'd0, busy}, 32'd1);
    snt = 1'b0;
    cyc();
    chk("done_pulse", {28'd0, cli_done}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset    = 1'b0;
    cli_req  = 4'b0000;
    cli_data = 32'h0;
    cli_mask = 4'b0000;
    snt      = 1'b0;
    cyc();
    cyc();
    chk("rst_vi", {31'd0, vi}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sdata", {24'd0, sdata}, 32'd0);
    chk("rst_gnt", {28'd0, cli_gnt}, 32'd0);
    chk("rst_done", {28'd0, cli_done}, 32'd0);
    chk("rst_cur_idx", {30'd0, cur_idx}, 32'd0);
    chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
    reset = 1'b1;

    // snt while idle and nothing requested must be ignored
    snt = 1'b1;
    cyc();
    chk("idle_snt_busy", {31'd0, busy}, 32'd0);
    chk("idle_snt_done", {28'd0, cli_done}, 32'd0);
    snt = 1'b0;

    // round robin, all four requesting
    cli_req  = 4'b1111;
    cli_data = {8'h13, 8'h12, 8'h11, 8'h10};
    serve(2'd0, 8'h10, 1);
    serve(2'd1, 8'h11, 1);
    serve(2'd2, 8'h12, 1);
    serve(2'd3, 8'h13, 1);
    serve(2'd0, 8'h10, 1);
    cli_req = 4'b0000;
    chk("rr_stall", {16'd0, stall_cnt}, 32'd5);

    // single client, snt three cycles after vi rises
    cli_req  = 4'b0100;
    cli_data = {8'h13, 8'hA5, 8'h11, 8'h10};
    serve(2'd2, 8'hA5, 3);
    cli_req = 4'b0000;
    chk("single_stall", {16'd0, stall_cnt}, 32'd8);

    // mask: ptr=3, client 0 masked -> client 1; then client 0 after wrap
    cli_req  = 4'b0011;
    cli_mask = 4'b0001;
    cli_data = {8'h13, 8'h12, 8'h11, 8'h10};
    serve(2'd1, 8'h11, 1);
    cli_req  = 4'b0001;
    cli_mask = 4'b0000;
    serve(2'd0, 8'h10, 1);
    cli_req = 4'b0000;

    // level snt held five cycles after completion
    cli_req = 4'b1000;
    cyc();
    chk("lvl_gnt", {28'd0, cli_gnt}, 32'h8);
    snt = 1'b1;
    cyc();
    chk("lvl_done", {28'd0, cli_done}, 32'h8);
    chk("lvl_vi", {31'd0, vi}, 32'd0);
    cli_req = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("lvl_done_once", {28'd0, cli_done}, 32'd0);
      chk("lvl_busy", {31'd0, busy}, 32'd1);
      chk("lvl_no_gnt", {28'd0, cli_gnt}, 32'd0);
    end
    snt = 1'b0;
    cyc();
    chk("lvl_idle", {31'd0, busy}, 32'd0);
    cyc();
    chk("lvl_next_gnt", {28'd0, cli_gnt}, 32'h4);
    snt = 1'b1;
    cyc();
    chk("lvl_next_done", {28'd0, cli_done}, 32'h4);
    snt = 1'b0;
    cli_req = 4'b0000;
    cyc();
    chk("lvl_stall", {16'd0, stall_cnt}, 32'd12);

    // mid-transfer drop and mask of the granted client
    cli_req  = 4'b0010;
    cli_data = {8'h13, 8'h12, 8'h5A, 8'h10};
    cyc();
    chk("mid_gnt", {28'd0, cli_gnt}, 32'h2);
    chk("mid_sdata", {24'd0, sdata}, 32'h5A);
    cli_req  = 4'b0000;
    cli_mask = 4'b0010;
    cli_data = {8'h13, 8'h12, 8'hFF, 8'h10};
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("mid_vi", {31'd0, vi}, 32'd1);
      chk("mid_sdata_hold", {24'd0, sdata}, 32'h5A);
    end
    snt = 1'b1;
    cyc();
    chk("mid_done", {28'd0, cli_done}, 32'h2);
    snt = 1'b0;
    cli_mask = 4'b0000;
    cyc();
    chk("mid_stall", {16'd0, stall_cnt}, 32'd15);

    // reset asserted mid-SEND, between edges
    cli_req  = 4'b1100;
    cli_data = {8'h13, 8'h12, 8'h11, 8'h10};
    cyc();
    chk("rs_gnt", {28'd0, cli_gnt}, 32'h4);
    cyc();
    chk("rs_vi", {31'd0, vi}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rs_vi_clr", {31'd0, vi}, 32'd0);
    chk("rs_busy_clr", {31'd0, busy}, 32'd0);
    chk("rs_sdata_clr", {24'd0, sdata}, 32'd0);
    chk("rs_stall_clr", {16'd0, stall_cnt}, 32'd0);
    cli_req = 4'b1001;
    cyc();
    reset = 1'b1;
    serve(2'd0, 8'h10, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/tx_share_arbiter.md
Name: tx_share_arbiter

Overview:
- Round-robin arbiter sharing one tx transmit port (vi/sdata/snt) among NCLI local requesters in the tx clock domain.
- Latches the winning client's word, drives it into tx, holds until tx reports snt, returns a done pulse to that client, then rotates priority.
- Sits between the producer clients and the tx half of the txrxsync pair; the clock-crossing handshake itself is untouched.

Parameters:
- NCLI, 4, number of requesting clients (2..8).
- IDXW, 2, width of client index; must satisfy 2**IDXW >= NCLI.
- DATA_MSB, 7, MSB of a data word (word width DATA_MSB+1).

Ports:
- clk  input  1  tx-domain clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- cli_req  input  NCLI  per-client request, level; held until matching cli_done.
- cli_data  input  NCLI*(DATA_MSB+1)  client words; client i at bits [i*(DATA_MSB+1) +: DATA_MSB+1].
- cli_mask  input  NCLI  1 = client excluded from arbitration (configuration).
- cli_gnt  output  NCLI  one-hot, one-cycle pulse: client's word captured.
- cli_done  output  NCLI  one-hot, one-cycle pulse: client's word accepted by tx.
- vi  output  1  valid to tx.
- sdata  output  DATA_MSB+1  word to tx; stable whenever vi=1.
- snt  input  1  tx sent indication, may be pulse or level.
- busy  output  1  high in any state other than IDLE.
- cur_idx  output  IDXW  index of client last granted.
- stall_cnt  output  16  saturating count of cycles spent in SEND.

Behaviour:
- Reset (reset=0, async): state=IDLE, vi=0, sdata=0, cli_gnt=0, cli_done=0, busy=0, cur_idx=0, rr pointer=0, stall_cnt=0. Outputs clear immediately, not at the next edge.
- Eligible set: E = cli_req & ~cli_mask.
- Arbitration: search E starting at index ptr, ascending, wrapping at NCLI-1 to 0. The first set bit wins.
- States:
  - IDLE: if E != 0, winner w is captured on the edge: sdata <= word w, cur_idx <= w, cli_gnt[w] pulses, vi <= 1, go to SEND. Else stay.
  - SEND: vi=1, sdata held, stall_cnt increments per cycle (saturates at 16'hFFFF). When snt=1 is sampled: vi <= 0, cli_done[cur_idx] pulses, ptr <= (cur_idx+1) mod NCLI, go to RELEASE.
  - RELEASE: vi=0. Wait until snt=0 is sampled, then go to IDLE. This guards against a level snt being counted twice.
- Latency:
  - Request seen in IDLE at edge k gives vi=1 and gnt pulse after edge k.
  - snt sampled at edge m gives vi=0 and done pulse after edge m.
  - With snt as a one-cycle pulse, the minimum gap from done to the next grant is 2 cycles (RELEASE then IDLE).
- A grant is never issued outside IDLE. The arbiter has at most one outstanding transfer.
- Changes during a transfer:
  - Changes to cli_req, cli_data or cli_mask during SEND/RELEASE do not affect the active transfer; the word is already latched.
  - Masking or dropping the granted client mid-transfer still completes the transfer, including its done pulse.
- snt=1 while IDLE is ignored.
- snt already high on entry to SEND (stale level) is treated as completion. Integration ensures tx deasserts snt before the next vi rise; the RELEASE state enforces this from the arbiter side.
- If NCLI < 2**IDXW, ptr wraps at NCLI, never to unused indices.
- stall_cnt is cumulative and cleared only by reset.
- A mid-transfer reset abandons the word silently; tx shares the same reset.

Test Plan:
- Single client: NCLI=4, cli_req=4'b0100, data2=8'hA5, snt pulses 3 cycles after vi rises. Required:
  - cli_gnt=4'b0100 for 1 cycle, vi=1, sdata=8'hA5 for 3 cycles.
  - cli_done=4'b0100 for 1 cycle, cur_idx=2.
- Round-robin: cli_req=4'b1111 held with distinct data 8'h10/11/12/13. Required: grants in order 0,1,2,3,0 and sdata sequence 10,11,12,13,10.
- Mask: cli_req=4'b0011, cli_mask=4'b0001. Required:
  - Only client 1 is served.
  - Clearing the mask serves client 0 next (ptr=2 wraps to 0).
- Level snt: snt held high 5 cycles after completion. Required:
  - Exactly one cli_done pulse.
  - Arbiter stays in RELEASE (busy=1) until snt=0; the next grant follows one cycle after.
- Mid-transfer changes: client 1 drops req and is masked during SEND. Required:
  - vi stays 1 and sdata stays unchanged.
  - cli_done[1] still pulses on snt.
- Reset mid-SEND: assert reset=0 between edges. Required:
  - vi, busy and sdata go to 0 immediately; stall_cnt=0.
  - After release, arbitration restarts from client 0.
